mod_n_counter_chain: RTL and testbench

Cascaded multi-digit counter. Each digit has its own terminal value, for example a 0..59 seconds field built as mod-10 plus mod-6. Supports up/down counting, synchronous parallel load and a chain carry-out for cascading further instances. Used in timer and clock display datapaths; it supersedes the single-digit fixed mod-10 counters.

---
 rtl/mod_n_counter_chain_pkg.sv | 25 ++
 rtl/mod_n_digit.sv | 45 ++++
 rtl/mod_n_counter_chain.sv | 89 ++++++++
 tb/tb_mod_n_counter_chain.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mod_n_counter_chain_pkg.sv
// Shared definitions for the cascaded mod-N digit counter: default digit width,
// common packed terminal-value sets and the count-direction encoding.
package mod_n_counter_chain_pkg;

  localparam int DIGIT_W_DEF = 4;

  // Packed per-digit terminal values, digit 0 in the low nibble.
  localparam logic [7:0] SEC_TERMS    = 8'h59;  // 00..59 seconds/minutes field
  // Each digit is counted independently; out-of-range loads clamp per digit.
  localparam logic [7:0] HOUR24_TERMS = 8'h23;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Load value limited to the digit's terminal value.
  function automatic logic [DIGIT_W_DEF-1:0] clamp_digit(
    input logic [DIGIT_W_DEF-1:0] val,
    input logic [DIGIT_W_DEF-1:0] term
  );
    return (val > term) ? term : val;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One counter digit holding 0..TERM: steps up or down with wrap, loads with
// clamping to TERM, and flags the terminal and zero states for the cascade.
module mod_n_digit
  import mod_n_counter_chain_pkg::*;
#(
  parameter int                 DIGIT_W = DIGIT_W_DEF,
  parameter logic [DIGIT_W-1:0] TERM    = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               up_dn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               at_term,
  output logic               at_zero
);

  logic [DIGIT_W-1:0] r_value;
  logic [DIGIT_W-1:0] w_load_clamped;
  logic [DIGIT_W-1:0] w_inc;
  logic [DIGIT_W-1:0] w_dec;

  assign w_load_clamped = (load_val > TERM) ? TERM : load_val;
  assign w_inc          = at_term ? '0 : r_value + DIGIT_W'(1);
  assign w_dec          = at_zero ? TERM : r_value - DIGIT_W'(1);

  // NOTE: non-blocking assignments so every digit samples the pre-edge state
  // of its neighbours, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= w_load_clamped;
    end else if (step) begin
      r_value <= up_dn ? w_inc : w_dec;
    end
  end

  assign value   = r_value;
  assign at_term = (r_value == TERM);
  assign at_zero = (r_value == '0);

endmodule

// File: rtl/mod_n_counter_chain.sv
// Cascaded multi-digit up/down counter with per-digit terminal values, clamped
// parallel load and combinational chain carry. Define COUNTER_SAT_EN to make the
// full chain saturate at its boundary instead of wrapping.
module mod_n_counter_chain
  import mod_n_counter_chain_pkg::*;
#(
  parameter int                         DIGITS  = 2,
  parameter int                         DIGIT_W = DIGIT_W_DEF,
  parameter logic [DIGITS*DIGIT_W-1:0]  TERMS   = SEC_TERMS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up_dn,
  input  logic                        load,
  input  logic [DIGITS*DIGIT_W-1:0]   load_val,
  output logic [DIGITS*DIGIT_W-1:0]   count,
  output logic [DIGITS-1:0]           digit_co,
  output logic                        co,
  output logic                        tc
);

  dir_e              w_dir;
  logic [DIGITS-1:0] w_at_term;
  logic [DIGITS-1:0] w_at_zero;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_adv;
  logic [DIGITS-1:0] w_wrap_pt;
  logic              w_all_term;
  logic              w_all_zero;
  logic              w_tc;
  logic              w_hold;

  assign w_dir = up_dn ? DIR_UP : DIR_DOWN;

  // Cascade enables: a digit steps when every lower digit sits at its wrap point.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    logic low_term;
    logic low_zero;
    w_step     = '0;
    low_term   = 1'b1;
    low_zero   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_step[i] = en & ((w_dir == DIR_UP) ? low_term : low_zero);
      low_term  = low_term & w_at_term[i];
      low_zero  = low_zero & w_at_zero[i];
    end
    w_all_term = low_term;
    w_all_zero = low_zero;
  end

  assign w_tc      = (w_dir == DIR_UP) ? w_all_term : w_all_zero;
  assign w_wrap_pt = (w_dir == DIR_UP) ? w_at_term : w_at_zero;

`ifdef COUNTER_SAT_EN
  assign w_hold = w_tc;
`else
  assign w_hold = 1'b0;
`endif

  assign w_adv = w_step & {DIGITS{~w_hold}};

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      mod_n_digit #(
        .DIGIT_W (DIGIT_W),
        .TERM    (TERMS[gi*DIGIT_W +: DIGIT_W])
      ) u_digit (
        .clk      (clk),
        .rst      (rst),
        .step     (w_adv[gi]),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val[gi*DIGIT_W +: DIGIT_W]),
        .value    (count[gi*DIGIT_W +: DIGIT_W]),
        .at_term  (w_at_term[gi]),
        .at_zero  (w_at_zero[gi])
      );
    end
  endgenerate

  assign digit_co = w_step & w_wrap_pt;
  assign tc       = w_tc;
  assign co       = en & w_tc;

endmodule

// File: tb/tb_mod_n_counter_chain.sv
// Scoreboard bench for mod_n_counter_chain: the reference model treats the
// chain as one mixed-radix integer and derives every output arithmetically.
module tb_mod_n_counter_chain;

  localparam int DIGITS  = 2;
  localparam int DIGIT_W = 4;
  localparam int W       = DIGITS * DIGIT_W;
  localparam logic [W-1:0] TERMS = 8'h59;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              up_dn = 1'b1;
  logic              load = 1'b0;
  logic [W-1:0]      load_val = '0;
  logic [W-1:0]      count;
  logic [DIGITS-1:0] digit_co;
  logic              co;
  logic              tc;

  mod_n_counter_chain #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W),
    .TERMS   (TERMS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .digit_co (digit_co),
    .co       (co),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]      count;
    logic              co;
    logic              tc;
    logic [DIGITS-1:0] dco;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   v      = 0;   // model count as a single integer 0..span(DIGITS)-1

  function automatic int modulus(int i);
    logic [W-1:0] t;
    t = TERMS;
    return int'(t[i*DIGIT_W +: DIGIT_W]) + 1;
  endfunction

  function automatic int span(int n);
    int p = 1;
    for (int j = 0; j < n; j++) p *= modulus(j);
    return p;
  endfunction

  function automatic logic [W-1:0] to_packed(int x);
    logic [W-1:0] p;
    p = '0;
    for (int j = 0; j < DIGITS; j++)
      p[j*DIGIT_W +: DIGIT_W] = DIGIT_W'((x / span(j)) % modulus(j));
    return p;
  endfunction

  function automatic int clamp_load(logic [W-1:0] lv);
    int x = 0;
    for (int j = 0; j < DIGITS; j++) begin
      int d;
      d = int'(lv[j*DIGIT_W +: DIGIT_W]);
      if (d > modulus(j) - 1) d = modulus(j) - 1;
      x += d * span(j);
    end
    return x;
  endfunction

  function automatic int next_v(int x, bit r, bit l, logic [W-1:0] lv, bit e, bit u);
    int tot = span(DIGITS);
    if (r) return 0;
    if (l) return clamp_load(lv);
    if (!e) return x;
    if (u) return (x == tot - 1) ? (SAT ? x : 0) : x + 1;
    return (x == 0) ? (SAT ? 0 : tot - 1) : x - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, push the outputs expected this cycle,
  // then advance the model to the state the next edge produces.
  task automatic cycle(input bit r, input bit l, input logic [W-1:0] lv,
                       input bit e, input bit u);
    exp_t x;
    int   tot;
    @(posedge clk);
    #1;
    rst = r; load = l; load_val = lv; en = e; up_dn = u;
    tot     = span(DIGITS);
    x.count = to_packed(v);
    x.tc    = u ? (v == tot - 1) : (v == 0);
    x.co    = e & x.tc;
    for (int i = 0; i < DIGITS; i++)
      x.dco[i] = e & (u ? ((v % span(i+1)) == span(i+1) - 1) : ((v % span(i+1)) == 0));
    sb_q.push_back(x);
    v = next_v(v, r, l, lv, e, u);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("count",    32'(count),    32'(e.count));
        check("co",       32'(co),       32'(e.co));
        check("tc",       32'(tc),       32'(e.tc));
        check("digit_co", 32'(digit_co), 32'(e.dco));
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    v = 0;

    // Reset mid-count: run to 37, pulse rst, then idle in up mode.
    for (int k = 0; k < 37; k++) cycle(0, 0, '0, 1, 1);
    cycle(1, 0, '0, 1, 1);
    cycle(0, 0, '0, 0, 1);

    // Up count through the full range and across the wrap.
    cycle(0, 1, 8'h00, 0, 1);
    for (int k = 0; k < 62; k++) cycle(0, 0, '0, 1, 1);

    // Down wrap from 00.
    cycle(0, 1, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, '0, 1, 0);

    // Load clamp with en high, then rst and load together.
    cycle(0, 1, 8'h7C, 1, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(1, 1, 8'h45, 1, 1);
    cycle(0, 0, '0, 0, 1);

    // Enable gating: en every other cycle.
    for (int k = 0; k < 20; k++) cycle(0, 0, '0, k[0], 1);

    // Terminal state with en low: tc without co, in both directions.
    cycle(0, 1, 8'h59, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 1, 8'h59, 0, 1);
    for (int k = 0; k < 4; k++) cycle(0, 0, '0, 1, 1);
    cycle(0, 1, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, '0, 1, 0);

    // Randomised traffic, direction changes on any cycle.
    for (int k = 0; k < 600; k++) begin
      bit           r, l, e, u;
      logic [W-1:0] lv;
      r  = ($urandom_range(99) < 2);
      l  = ($urandom_range(99) < 8);
      e  = ($urandom_range(99) < 75);
      u  = ($urandom_range(99) < 60);
      lv = W'($urandom);
      cycle(r, l, lv, e, u);
    end

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
